alu_seq: RTL
============

Name: alu_seq

Overview:
- Parametrised, handshaked successor to the 4-bit combinational ALU.
- Adds WIDTH generalisation, registered result and flags, shift and compare ops, and a multi-cycle shift-add multiplier.
- Sits between operand source (switches/CPU decode) and result consumer (7-seg driver/writeback) using a valid/ready handshake on both sides.

Parameters:
- WIDTH, 4, operand/result width in bits; legal range 2..32.
- SHW, derived localparam = clog2(WIDTH); shift amount is B[SHW-1:0].

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operands/op valid.
- in_ready  out  1  block can accept; high only in IDLE.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- op  in  4  operation select.
- out_valid  out  1  result/flags valid.
- out_ready  in  1  consumer accepts result.
- result  out  WIDTH  registered result.
- flag_z  out  1  result == 0.
- flag_c  out  1  carry (ADD) / borrow (SUB).
- flag_v  out  1  signed overflow (ADD/SUB).
- flag_n  out  1  result MSB.
- flag_err  out  1  illegal or disabled op.

Behaviour:
- Reset: state=IDLE; result=0; all flags=0; out_valid=0; in_ready=1. Reset has priority over every other event, including mid-MUL and a pending DONE.
- Op encoding:
  - 0 ADD: a+b.
  - 1 SUB: a-b (two's complement: a + ~b + 1).
  - 2 NOT: ~a.
  - 3 AND, 4 OR, 5 XOR.
  - 6 SLT: signed a<b, zero-extended.
  - 7 EQ: a==b, zero-extended.
  - 8 SLTU: unsigned a<b.
  - 9 SLL, 10 SRL, 11 SRA: shift by b[SHW-1:0]. A shift amount >= WIDTH gives 0 for SLL/SRL and all sign bits for SRA.
  - 12 MUL: low WIDTH bits of a*b, unsigned.
  - 13-15: illegal.
- Flags:
  - ADD: flag_c = carry out of bit WIDTH-1.
  - SUB: flag_c = 1 iff a<b unsigned (borrow).
  - flag_v: ADD/SUB signed overflow only.
  - flag_c and flag_v are 0 for all other ops.
  - flag_z and flag_n are computed from result for every op.
  - flag_err = 1 only for illegal ops; result = 0 in that case.
- FSM states: IDLE, BUSY, DONE.
  - IDLE: in_ready=1. On in_valid, latch a/b/op.
    - Non-MUL op: compute and register result/flags → DONE; out_valid is high the cycle after acceptance (latency 1).
    - MUL: clear accumulator, load counter = WIDTH → BUSY.
  - BUSY: in_ready=0, out_valid=0. Each cycle: if multiplier LSB is 1, add multiplicand to accumulator; multiplicand <<1; multiplier >>1; counter−1.
    - When counter reaches 0, register result → DONE.
    - Acceptance to out_valid = WIDTH+1 cycles.
  - DONE: out_valid=1, in_ready=0. result and flags are held stable until out_ready=1.
    - On out_valid && out_ready: → IDLE; out_valid drops next cycle.
    - result and flags keep their last value after the handshake; only out_valid qualifies them.
    - No new input is accepted in the same cycle as an output handshake; back-to-back throughput is 1 op per 2 cycles.
- in_valid is ignored when in_ready=0. Input ports may change freely outside the accept cycle.
- Arithmetic is internally WIDTH+1 bits for carry; no other widening.

Optional Feature:
- Macro: ALU_SEQ_MUL_EN.
- Defined: op 12 behaves as MUL above (BUSY path present).
- Undefined:
  - No BUSY state or multiplier datapath is synthesised.
  - op 12 is treated as illegal: 1-cycle latency, result=0, flag_err=1.

Test Plan (WIDTH=4):
- ADD a=7, b=9 → after 1 cycle out_valid=1, result=0, flag_c=1, flag_z=1, flag_v=0, flag_n=0.
- SUB a=8, b=1 → result=7, flag_v=1, flag_c=0, flag_n=0; then SUB a=1, b=2 → result=15, flag_c=1, flag_n=1.
- MUL a=5, b=3 with ALU_SEQ_MUL_EN → in_ready low for 5 cycles, out_valid on cycle 5 after accept, result=15. Without the macro → result=0, flag_err=1 after 1 cycle.
- SRA a=4'b1000, b=3 → result=4'b1111. SLT a=4'b1111 (−1), b=1 → result=1. SLTU same operands → result=0.
- Backpressure: XOR a=5, b=3 with out_ready=0 for 4 cycles → out_valid stays 1, result=6 stable, in_ready=0 and a new in_valid is ignored. Raising out_ready → IDLE on the next cycle.
- Reset: assert rst on the 2nd BUSY cycle of MUL 7×7 → next cycle IDLE, out_valid=0, result=0, flags=0, in_ready=1. Illegal op 14 afterwards → result=0, flag_err=1.

Source files
------------

// File: rtl/alu_seq.sv
// Sequential ALU with valid/ready handshake on input and output, registered result and flags.
// Define ALU_SEQ_MUL_EN to build the multi-cycle shift-add multiplier (op 12); otherwise op 12 is illegal.
module alu_seq #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             flag_z,
  output logic             flag_c,
  output logic             flag_v,
  output logic             flag_n,
  output logic             flag_err
);

  localparam int SHW = $clog2(WIDTH);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_NOT  = 4'd2;
  localparam logic [3:0] OP_AND  = 4'd3;
  localparam logic [3:0] OP_OR   = 4'd4;
  localparam logic [3:0] OP_XOR  = 4'd5;
  localparam logic [3:0] OP_SLT  = 4'd6;
  localparam logic [3:0] OP_EQ   = 4'd7;
  localparam logic [3:0] OP_SLTU = 4'd8;
  localparam logic [3:0] OP_SLL  = 4'd9;
  localparam logic [3:0] OP_SRL  = 4'd10;
  localparam logic [3:0] OP_SRA  = 4'd11;

`ifdef ALU_SEQ_MUL_EN
  localparam logic [1:0] ST_BUSY  = 2'd1;
  localparam logic [3:0] OP_MUL   = 4'd12;
  localparam logic [SHW:0] CNT_INIT = (SHW+1)'(WIDTH);

  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [SHW:0]     cnt;
`endif

  logic [1:0]       state;
  logic [WIDTH:0]   sum_add;
  logic [WIDTH:0]   sum_sub;
  logic [SHW-1:0]   sh;
  logic             sh_over;
  logic [WIDTH-1:0] calc_res;
  logic             calc_c;
  logic             calc_v;
  logic             calc_err;

  assign sum_add = {1'b0, a} + {1'b0, b};
  assign sum_sub = {1'b0, a} + {1'b0, ~b} + (WIDTH+1)'(1);
  assign sh      = b[SHW-1:0];
  // Only reachable when WIDTH is not a power of two.
  assign sh_over = int'(sh) >= WIDTH;

  always_comb begin
    calc_res = '0;
    calc_c   = 1'b0;
    calc_v   = 1'b0;
    calc_err = 1'b0;
    case (op)
      OP_ADD: begin
        calc_res = sum_add[WIDTH-1:0];
        calc_c   = sum_add[WIDTH];
        calc_v   = (a[WIDTH-1] == b[WIDTH-1]) && (sum_add[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        calc_res = sum_sub[WIDTH-1:0];
        calc_c   = ~sum_sub[WIDTH];
        calc_v   = (a[WIDTH-1] != b[WIDTH-1]) && (sum_sub[WIDTH-1] != a[WIDTH-1]);
      end
      OP_NOT:  calc_res = ~a;
      OP_AND:  calc_res = a & b;
      OP_OR:   calc_res = a | b;
      OP_XOR:  calc_res = a ^ b;
      OP_SLT:  calc_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_EQ:   calc_res = {{(WIDTH-1){1'b0}}, (a == b)};
      OP_SLTU: calc_res = {{(WIDTH-1){1'b0}}, (a < b)};
      OP_SLL:  calc_res = sh_over ? '0 : (a << sh);
      OP_SRL:  calc_res = sh_over ? '0 : (a >> sh);
      OP_SRA:  calc_res = sh_over ? {WIDTH{a[WIDTH-1]}} : WIDTH'($signed(a) >>> sh);
      default: calc_err = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      result   <= '0;
      flag_z   <= 1'b0;
      flag_c   <= 1'b0;
      flag_v   <= 1'b0;
      flag_n   <= 1'b0;
      flag_err <= 1'b0;
`ifdef ALU_SEQ_MUL_EN
      acc      <= '0;
      mcand    <= '0;
      mplier   <= '0;
      cnt      <= '0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
`ifdef ALU_SEQ_MUL_EN
            if (op == OP_MUL) begin
              acc    <= '0;
              mcand  <= a;
              mplier <= b;
              cnt    <= CNT_INIT;
              state  <= ST_BUSY;
            end else begin
`else
            begin
`endif
              result   <= calc_res;
              flag_z   <= (calc_res == '0);
              flag_c   <= calc_c;
              flag_v   <= calc_v;
              flag_n   <= calc_res[WIDTH-1];
              flag_err <= calc_err;
              state    <= ST_DONE;
            end
          end
        end
`ifdef ALU_SEQ_MUL_EN
        ST_BUSY: begin
          // One partial product per cycle; the extra cycle at cnt==0 publishes the sum.
          if (cnt != '0) begin
            if (mplier[0]) acc <= acc + mcand;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt - 1'b1;
          end else begin
            result   <= acc;
            flag_z   <= (acc == '0);
            flag_c   <= 1'b0;
            flag_v   <= 1'b0;
            flag_n   <= acc[WIDTH-1];
            flag_err <= 1'b0;
            state    <= ST_DONE;
          end
        end
`endif
        ST_DONE: begin
          if (out_ready) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign in_ready  = (state == ST_IDLE);
  assign out_valid = (state == ST_DONE);

endmodule
